// File: rtl/mem_arb_ram.sv
// Shared single-port word RAM, N_CH valid/ready channels, round-robin grant.
// Optional MEM_PARITY_EN adds a stored even-parity bit per word and rsp_err.
module mem_arb_ram #(
    parameter int WORD_SIZE = 64,
    parameter int DEPTH     = 64,
    parameter int N_CH      = 4,
    localparam int ADDR_SIZE = $clog2(DEPTH),
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CH-1:0]             req_valid,
    output logic [N_CH-1:0]             req_ready,
    input  logic [N_CH-1:0]             req_we,
    input  logic [N_CH*ADDR_SIZE-1:0]   req_addr,
    input  logic [N_CH*WORD_SIZE-1:0]   req_wdata,
    output logic                        rsp_valid,
    output logic [CH_W-1:0]             rsp_ch,
    output logic [WORD_SIZE-1:0]        rsp_rdata,
    output logic                        rsp_err,
    input  logic                        inj_par_err
);

    logic [WORD_SIZE-1:0] mem [DEPTH];

    logic [CH_W-1:0]      ptr;
    logic [CH_W-1:0]      gidx;
    logic [CH_W-1:0]      ptr_nxt;
    logic                 found;
    logic                 acc;
    logic                 sel_we;
    logic [ADDR_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0] sel_wdata;
    logic                 in_range;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_err;

    // Search starts at ptr and wraps, so the last winner goes to the back.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < N_CH; i++) begin
            j = (int'(ptr) + i) % N_CH;
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gidx  = CH_W'(j);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && !rst) begin
            req_ready[gidx] = 1'b1;
        end
    end

    assign acc       = |(req_valid & req_ready);
    assign sel_we    = req_we[gidx];
    assign sel_addr  = req_addr[int'(gidx)*ADDR_SIZE +: ADDR_SIZE];
    assign sel_wdata = req_wdata[int'(gidx)*WORD_SIZE +: WORD_SIZE];
    assign ptr_nxt   = (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + CH_W'(1);

    generate
        if ((1 << ADDR_SIZE) == DEPTH) begin : g_pow2
            assign in_range = 1'b1;
        end else begin : g_npow2
            assign in_range = sel_addr < ADDR_SIZE'(DEPTH);
        end
    endgenerate

    assign rd_data = in_range ? mem[sel_addr] : '0;

`ifdef MEM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (acc && sel_we && in_range) begin
            par_mem[sel_addr] <= (^sel_wdata) ^ inj_par_err;
        end
    end

    assign rd_err = in_range &&
                    ((^mem[sel_addr]) != par_mem[sel_addr]);
`else
    logic unused_inj;
    assign unused_inj = inj_par_err;
    assign rd_err     = 1'b0;
`endif

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (acc && sel_we && in_range) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_ch    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= acc && !sel_we;
            if (acc) begin
                ptr <= ptr_nxt;
            end
            if (acc && !sel_we) begin
                rsp_ch    <= gidx;
                rsp_rdata <= rd_data;
                rsp_err   <= rd_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_ram.sv
// Bench for mem_arb_ram: directed scenarios plus randomized traffic
// against a queue/array reference model; second instance covers DEPTH=48.
module tb_mem_arb_ram;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [3:0]   req_we = '0;
    logic [23:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic         rsp_valid;
    logic [1:0]   rsp_ch;
    logic [63:0]  rsp_rdata;
    logic         rsp_err;
    logic         inj = 1'b0;

    logic         v2 = 1'b0;
    logic         r2;
    logic         we2 = 1'b0;
    logic [5:0]   a2 = '0;
    logic [63:0]  d2 = '0;
    logic         inj2 = 1'b0;
    logic         rv2;
    logic [0:0]   rch2;
    logic [63:0]  rd2;
    logic         re2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int          mptr;
    logic [63:0] mmem [64];
    bit          exp_v;
    logic [1:0]  exp_ch;
    logic [63:0] exp_d;
    int          last_g;

    always #5 clk = ~clk;

    mem_arb_ram #(.WORD_SIZE(64), .DEPTH(64), .N_CH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ch(rsp_ch),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .inj_par_err(inj)
    );

    mem_arb_ram #(.WORD_SIZE(64), .DEPTH(48), .N_CH(1)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_ready(r2),
        .req_we(we2), .req_addr(a2),
        .req_wdata(d2),
        .rsp_valid(rv2), .rsp_ch(rch2),
        .rsp_rdata(rd2), .rsp_err(re2),
        .inj_par_err(inj2)
    );

    function automatic int model_grant(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (mptr + i) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int g);
        logic [3:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        mptr   = 0;
        exp_v  = 0;
        exp_ch = '0;
        exp_d  = '0;
        last_g = -1;
    endtask

    task automatic set_req(int k, bit we, int a, logic [63:0] d);
        req_we[k]          = we;
        req_addr[k*6 +: 6] = a[5:0];
        req_wdata[k*64 +: 64] = d;
    endtask

    // Advance one edge and apply the accepted request to the model.
    task automatic tick();
        int g;
        int a;
        g = model_grant(req_valid);
        @(posedge clk);
        exp_v = 0;
        if (g >= 0) begin
            a = int'(req_addr[g*6 +: 6]);
            if (req_we[g]) begin
                mmem[a] = req_wdata[g*64 +: 64];
            end else begin
                exp_v  = 1;
                exp_ch = 2'(g);
                exp_d  = mmem[a];
            end
            mptr = (g + 1) % 4;
        end
        last_g = g;
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_ch !== 2'd0 ||
            rsp_rdata !== 64'd0 || rsp_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_rsp got v=%b ch=%0d d=%h e=%b want 0",
                     rsp_valid, rsp_ch, rsp_rdata, rsp_err);
        end
        req_valid = '0;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_fill();
        for (int a = 0; a < 64; a++) begin
            set_req(0, 1'b1, a, {$urandom, $urandom});
            req_valid = 4'b0001;
            @(negedge clk);
            tests_run++;
            if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL fill a=%0d got rdy=%b v=%b want 0001 0",
                         a, req_ready, rsp_valid);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5, 64'hDEAD_BEEF);
        req_valid = 4'b0010;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL single_wr_rdy got %b want 0010", req_ready);
        end
        tick();
        set_req(1, 1'b0, 5, '0);
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rd_rdy got %b v=%b want 0010 0",
                     req_ready, rsp_valid);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 ||
            rsp_rdata !== 64'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_rsp got v=%b ch=%0d d=%h want 1 1 deadbeef",
                     rsp_valid, rsp_ch, rsp_rdata);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL single_hold got v=%b d=%h want 0 deadbeef",
                     rsp_valid, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_fairness();
        int ord [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, k, '0);
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            tests_run++;
            if (req_ready !== onehot(ord[c])) begin
                tests_failed++;
                $display("FAIL fair_grant c=%0d got %b want %b",
                         c, req_ready, onehot(ord[c]));
            end
            if (c > 0) begin
                tests_run++;
                if (rsp_valid !== 1'b1 || rsp_ch !== 2'(ord[c-1]) ||
                    rsp_rdata !== mmem[ord[c-1]]) begin
                    tests_failed++;
                    $display("FAIL fair_rsp c=%0d got v=%b ch=%0d want ch %0d",
                             c, rsp_valid, rsp_ch, ord[c-1]);
                end
            end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 ||
            rsp_rdata !== mmem[1]) begin
            tests_failed++;
            $display("FAIL fair_last got v=%b ch=%0d want 1 1",
                     rsp_valid, rsp_ch);
        end
        tick();
    endtask

    task automatic test_wrap();
        set_req(3, 1'b0, 3, '0);
        req_valid = 4'b1000;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_ch3 got %b want 1000", req_ready);
        end
        tick();
        set_req(0, 1'b0, 0, '0);
        set_req(2, 1'b0, 2, '0);
        req_valid = 4'b0101;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL wrap_first got %b want 0001", req_ready);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL wrap_second got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_raw();
        set_req(0, 1'b1, 9, 64'h1234);
        req_valid = 4'b0001;
        tick();
        set_req(2, 1'b0, 9, '0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_ch !== 2'd2 ||
            rsp_rdata !== 64'h1234) begin
            tests_failed++;
            $display("FAIL raw got v=%b ch=%0d d=%h want 1 2 1234",
                     rsp_valid, rsp_ch, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b0, 9, '0);
        set_req(1, 1'b0, 1, '0);
        req_valid = 4'b0011;
        tick();
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 ||
            req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rstmid_now got v=%b d=%h rdy=%b want 0 0 0",
                     rsp_valid, rsp_rdata, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL rstmid_drop c=%0d got v=%b want 0",
                         c, rsp_valid);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) set_req(k, 1'b0, k, '0);
        req_valid = 4'hF;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rstmid_ptr got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int g;
        for (int k = 0; k < 4; k++) begin
            set_req(k, 1'($urandom), $urandom_range(0, 63),
                    {$urandom, $urandom});
        end
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            @(negedge clk);
            g = model_grant(req_valid);
            tests_run++;
            if (req_ready !== onehot(g)) begin
                tests_failed++;
                $display("FAIL rnd_grant c=%0d got %b want %b",
                         c, req_ready, onehot(g));
            end
            tests_run++;
            if (rsp_valid !== exp_v || rsp_ch !== exp_ch ||
                rsp_rdata !== exp_d || rsp_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd_rsp c=%0d got v=%b ch=%0d d=%h e=%b want %b %0d %h 0",
                         c, rsp_valid, rsp_ch, rsp_rdata, rsp_err,
                         exp_v, exp_ch, exp_d);
            end
            tick();
            if (last_g >= 0) begin
                set_req(last_g, 1'($urandom), $urandom_range(0, 63),
                        {$urandom, $urandom});
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_oor();
        logic [63:0] da;
        logic [63:0] db;
        int          ad [3] = '{47, 7, 50};
        logic        ex_err [3];
        logic [63:0] ex_d [3];
        da = {$urandom, $urandom};
        db = {$urandom, $urandom};
        ex_d[0] = da;
        ex_d[1] = db;
        ex_d[2] = 64'd0;
        ex_err[0] = 1'b0;
`ifdef MEM_PARITY_EN
        ex_err[1] = 1'b1;
`else
        ex_err[1] = 1'b0;
`endif
        ex_err[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v2   = 1'b1;
            we2  = 1'b1;
            a2   = 6'(ad[i]);
            d2   = (i == 0) ? da : (i == 1) ? db : 64'hFFFF_0000_FFFF_0000;
            inj2 = (i == 1);
            @(negedge clk);
            tests_run++;
            if (r2 !== 1'b1) begin
                tests_failed++;
                $display("FAIL oor_wr_rdy a=%0d got %b want 1", ad[i], r2);
            end
            @(posedge clk);
            #1;
        end
        inj2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v2  = 1'b1;
            we2 = 1'b0;
            a2  = 6'(ad[i]);
            @(posedge clk);
            #1;
            v2 = 1'b0;
            @(negedge clk);
            tests_run++;
            if (rv2 !== 1'b1 || rch2 !== 1'b0 ||
                rd2 !== ex_d[i] || re2 !== ex_err[i]) begin
                tests_failed++;
                $display("FAIL oor_rd a=%0d got v=%b ch=%0d d=%h e=%b want 1 0 %h %b",
                         ad[i], rv2, rch2, rd2, re2, ex_d[i], ex_err[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_single();
        test_fairness();
        test_wrap();
        test_raw();
        test_reset_mid();
        test_random();
        test_oor();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
